// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: opcodes, forwarding select,
// FSM states, the buffered entry layout and the forwarding-select helper.
package alu_issue_stage_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_idx_t;

   // ALU opcode encoding; 4'd9..4'd15 are illegal and are issued as ADD.
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLL = 4'd5,
      OP_SRL = 4'd6,
      OP_SLT = 4'd7,
      OP_HLT = 4'd8
   } opcode_e;

   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EXM  = 2'd1,
      FWD_WB   = 2'd2
   } fwd_sel_e;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_PEND = 2'd1,
      HALTED    = 2'd2
   } state_e;

   // One buffered operation, already forwarded and opcode-sanitised.
   typedef struct packed {
      word_t       op1;
      word_t       op2;
      logic [3:0]  opcode;
      reg_idx_t    rd;
   } issue_entry_t;

   // EX/MEM wins over MEM/WB; register 0 is never forwarded.
   function automatic fwd_sel_e fwd_select(input logic     en,
                                           input reg_idx_t idx,
                                           input logic     exm_wen,
                                           input reg_idx_t exm_rd,
                                           input logic     wb_wen,
                                           input reg_idx_t wb_rd);
      fwd_sel_e sel;
      sel = FWD_NONE;
      if (en && (idx != '0)) begin
         if (exm_wen && (exm_rd == idx)) sel = FWD_EXM;
         else if (wb_wen && (wb_rd == idx)) sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side input bus and ALU-side output bus of the issue stage.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holding valid keeps its payload stable until the
// transfer, and ready never depends on a combinational path through the
// payload.
interface alu_issue_stage_if;
   import alu_issue_stage_pkg::*;

   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   word_t       in_rs_val;
   word_t       in_rt_val;
   word_t       in_imm;
   logic        in_use_imm;
   reg_idx_t    in_rs_idx;
   reg_idx_t    in_rt_idx;
   reg_idx_t    in_rd_idx;

   logic        out_valid;
   logic        out_ready;
   word_t       op1;
   word_t       op2;
   logic [3:0]  opcode;
   reg_idx_t    out_rd;

   // Decode + ALU side (drives operations in, accepts results out).
   modport master (
      output in_valid, in_opcode, in_rs_val, in_rt_val, in_imm, in_use_imm,
             in_rs_idx, in_rt_idx, in_rd_idx, out_ready,
      input  in_ready, out_valid, op1, op2, opcode, out_rd
   );

   // Issue stage.
   modport slave (
      input  in_valid, in_opcode, in_rs_val, in_rt_val, in_imm, in_use_imm,
             in_rs_idx, in_rt_idx, in_rd_idx, out_ready,
      output in_ready, out_valid, op1, op2, opcode, out_rd
   );
endinterface

// File: rtl/alu_issue_stage_skid_buf.sv
// Two-entry elastic buffer: the main entry drives the outputs directly
// (registered), the skid entry absorbs one push while main is stalled.
module issue_skid_buf
   import alu_issue_stage_pkg::*;
(
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  issue_entry_t i_data,
   input  logic         i_pop_ready,
   output logic         o_main_valid,
   output issue_entry_t o_main,
   output logic         o_skid_full
);

   logic         r_main_v;
   logic         r_skid_v;
   issue_entry_t r_main;
   issue_entry_t r_skid;
   logic         w_main_free;

   // Main can take new data when it is empty or being consumed this cycle.
   assign w_main_free = !r_main_v || i_pop_ready;

   // Entry update: skid drains into main first; pushes never arrive while skid is full.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_main   <= '0;
         r_skid   <= '0;
      end else if (i_flush) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else if (w_main_free) begin
         if (r_skid_v) begin
            r_main   <= r_skid;
            r_main_v <= 1'b1;
            r_skid_v <= 1'b0;
         end else begin
            r_main_v <= i_push;
            if (i_push) r_main <= i_data;
         end
      end else if (i_push) begin
         r_skid   <= i_data;
         r_skid_v <= 1'b1;
      end
   end

   assign o_main_valid = r_main_v;
   assign o_main       = r_main;
   assign o_skid_full  = r_skid_v;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: resolves operand forwarding at capture, sanitises the
// opcode, buffers up to two operations and tracks the halt sequence.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter logic FWD_EN = 1'b1
) (
   input  logic               CLK,
   input  logic               RST,
   alu_issue_stage_if.slave   bus,
   input  logic               exm_wen,
   input  reg_idx_t           exm_rd,
   input  word_t              exm_data,
   input  logic               wb_wen,
   input  reg_idx_t           wb_rd,
   input  word_t              wb_data,
   input  logic               flush,
   output logic               halted,
   output logic               illegal_op,
   output logic [15:0]        stall_cnt,
   output state_e             o_dbg_state
);

   state_e       r_state;
   state_e       w_state_nxt;
   logic         r_illegal;
   logic [15:0]  r_stall_cnt;

   logic         w_in_ready;
   logic         w_push;
   logic         w_pop;
   logic         w_flush;
   logic         w_illegal_in;
   fwd_sel_e     w_sel1;
   fwd_sel_e     w_sel2;
   issue_entry_t w_entry;
   issue_entry_t w_main;
   logic         w_main_valid;
   logic         w_skid_full;

   // Flush is ignored once halted; only reset leaves HALTED.
   assign w_flush    = flush && (r_state != HALTED);
   assign w_in_ready = !RST && !w_skid_full && (r_state == RUN) && !flush;
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_pop      = w_main_valid && bus.out_ready;

   assign w_sel1       = fwd_select(FWD_EN, bus.in_rs_idx, exm_wen, exm_rd, wb_wen, wb_rd);
   assign w_sel2       = fwd_select(FWD_EN, bus.in_rt_idx, exm_wen, exm_rd, wb_wen, wb_rd);
   assign w_illegal_in = (bus.in_opcode > OP_HLT);

   // Capture-time operand selection and opcode sanitising.
   always_comb begin
      w_entry.op1    = bus.in_rs_val;
      w_entry.op2    = bus.in_rt_val;
      w_entry.opcode = w_illegal_in ? OP_ADD : bus.in_opcode;
      w_entry.rd     = bus.in_rd_idx;
      case (w_sel1)
         FWD_EXM: w_entry.op1 = exm_data;
         FWD_WB:  w_entry.op1 = wb_data;
         default: ;
      endcase
      case (w_sel2)
         FWD_EXM: w_entry.op2 = exm_data;
         FWD_WB:  w_entry.op2 = wb_data;
         default: ;
      endcase
      if (bus.in_use_imm) w_entry.op2 = bus.in_imm;
   end

   issue_skid_buf u_skid_buf (
      .i_clk        (CLK),
      .i_rst        (RST),
      .i_flush      (w_flush),
      .i_push       (w_push),
      .i_data       (w_entry),
      .i_pop_ready  (bus.out_ready),
      .o_main_valid (w_main_valid),
      .o_main       (w_main),
      .o_skid_full  (w_skid_full)
   );

   // Halt sequencing; an issued HLT takes precedence over a same-cycle flush.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN: begin
            if (w_push && (w_entry.opcode == OP_HLT)) w_state_nxt = HALT_PEND;
         end
         HALT_PEND: begin
            if (w_pop && (w_main.opcode == OP_HLT)) w_state_nxt = HALTED;
            else if (flush)                          w_state_nxt = RUN;
         end
         HALTED:  w_state_nxt = HALTED;
         default: w_state_nxt = RUN;
      endcase
   end

   // State, sticky illegal flag and saturating stall counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= RUN;
         r_illegal   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push && w_illegal_in) r_illegal <= 1'b1;
         if (w_main_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_main_valid;
   assign bus.op1       = w_main.op1;
   assign bus.op2       = w_main.op2;
   assign bus.opcode    = w_main.opcode;
   assign bus.out_rd    = w_main.rd;
   assign halted        = (r_state == HALTED);
   assign illegal_op    = r_illegal;
   assign stall_cnt     = r_stall_cnt;
   assign o_dbg_state   = r_state;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: FWD_EN, 1, operand forwarding enable; 0 bypasses all forwarding muxes.
REQ-002 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-003 Port: RST  in  1  synchronous, active-high reset.
REQ-004 Port: in_valid  in  1  decode presents an operation.
REQ-005 Port: in_ready  out  1  stage accepts the operation this cycle.
REQ-006 Port: in_opcode  in  4  ALU opcode (alu_pkg encoding).
REQ-007 Port: in_rs_val, in_rt_val  in  32 each  register-file read data (word_t).
REQ-008 Port: in_imm  in  32  extended immediate; in_use_imm  in  1  selects imm as op2.
REQ-009 Port: in_rs_idx, in_rt_idx, in_rd_idx  in  5 each  source/destination register indices.
REQ-010 Port: exm_wen  in  1, exm_rd  in  5, exm_data  in  32  EX/MEM forwarding source.
REQ-011 Port: wb_wen  in  1, wb_rd  in  5, wb_data  in  32  MEM/WB forwarding source.
REQ-012 Port: flush  in  1  discard all buffered operations.
REQ-013 Port: out_valid  out  1, out_ready  in  1  handshake to the ALU/EX-MEM side.
REQ-014 Port: op1, op2  out  32, opcode  out  4, out_rd  out  5  operands and opcode driven to the alu_if alum inputs.
REQ-015 Port: halted  out  1; illegal_op  out  1 sticky; stall_cnt  out  16 saturating.

Function
REQ-016 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-017 Storage is a two-entry elastic buffer (main + skid); in_ready = skid empty && state==RUN && !flush.
REQ-018 Throughput: one op per cycle with out_ready held high; latency from input transfer to out_valid is 1 cycle.
REQ-019 op1, op2, opcode, out_rd are registered and are held stable while out_valid && !out_ready.
REQ-020 Forwarding is resolved at capture: exm source has priority over wb; a match requires wen=1 and rd==idx!=0.
REQ-021 Index 0 is never forwarded; with FWD_EN=0, op1/op2 equal in_rs_val/in_rt_val.
REQ-022 op2 = in_imm when in_use_imm=1, with no forwarding applied to op2.
REQ-023 in_opcode 4'b1001-4'b1111 is replaced by ADD on capture and sets illegal_op until RST.
REQ-024 FSM states: RUN, HALT_PEND, HALTED.
REQ-025 RUN->HALT_PEND on input transfer of HLT.
REQ-026 HALT_PEND->HALTED on output transfer of HLT.
REQ-027 HALT_PEND->RUN on flush.
REQ-028 HALTED is left only by RST; halted=1 only in HALTED; in_ready=0 outside RUN.
REQ-029 flush empties both entries at the next edge, overrides a same-cycle in_valid, and has no effect in HALTED.
REQ-030 stall_cnt increments each cycle with out_valid && !out_ready and saturates at 16'hFFFF.

Reset
REQ-031 On RST all outputs are 0, both entries are empty, state=RUN, and illegal_op=0, stall_cnt=0.
REQ-032 RST mid-stall or in HALT_PEND discards buffered ops; in_ready=1 the cycle after RST deasserts.

Structure
REQ-033 Forwarding select enum (FWD_NONE, FWD_EXM, FWD_WB) and the FSM state enum belong in a shared package alongside the alu_pkg opcodes.
REQ-034 The two-entry buffer is the sub-module issue_skid_buf, instantiated once; forwarding and FSM logic stay in the top level.

Verification
REQ-035 Back-to-back: 4 ADDs, out_ready=1 -> 4 outputs on consecutive cycles with 1-cycle latency and in_ready constant 1.
REQ-036 Backpressure: out_ready=0 for 3 cycles with 2 ops sent -> second op held in skid, in_ready=0, op1/op2 stable, stall_cnt=3, then both ops drain in order.
REQ-037 Forwarding: rs_idx=5, exm_wen=1/exm_rd=5/exm_data=32'hAAAA, wb_rd=5/wb_data=32'hBBBB -> op1=32'hAAAA; rs_idx=0 with exm_rd=0 -> op1=in_rs_val.
REQ-038 Halt: HLT followed by SUB -> SUB rejected, HLT issued, halted=1 thereafter; flush in HALTED -> no effect.
REQ-039 Flush and reset: flush with 2 buffered ops and in_valid=1 -> out_valid=0 next cycle; in_opcode=4'b1100 -> opcode=ADD and illegal_op=1 until RST.
